// File: rtl/hex_display_pkg.sv
// Shared types and constants for the four-digit multiplexed hex display.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package hex_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEAD,
      ST_DRIVE
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   localparam logic [0:15][6:0] SEG_TABLE = {
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_seg_decoder
   import hex_display_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg_n
);

   assign o_seg_n = SEG_TABLE[i_nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Four-digit multiplexed hex display scanner with per-slot dead time,
// frame-aligned input snapshots and optional leading-zero blanking.
module hex_display_scanner
   import hex_display_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 50000,
   parameter int unsigned DEAD_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] value_in,
   input  logic [3:0]  dp_in,
   input  logic        blank_lz,
   input  logic        enable,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [3:0]  an_n,
   output logic        frame_tick
);

   localparam int unsigned CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] PRESC_LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_CYCLES - 1);

   state_t        r_state, w_state_next;
   logic [CW-1:0] r_presc, w_presc_next;
   logic [1:0]    r_index, w_index_next;
   logic          w_load;
   logic          w_slot_end;

   logic [15:0]   r_value;
   logic [3:0]    r_dp;
   logic          r_blz;

   logic [6:0]    r_seg;
   logic          r_dp_n;
   logic [3:0]    r_an;
   logic          r_frame_tick;

   logic [3:0]    w_nibble;
   logic [6:0]    w_seg_dec;
   logic          w_blank;

   assign w_slot_end = (r_presc == PRESC_LAST);

   always_comb begin
      w_state_next = r_state;
      w_presc_next = r_presc;
      w_index_next = r_index;
      w_load       = 1'b0;
      if (!enable) begin
         w_state_next = ST_IDLE;
         w_presc_next = '0;
         w_index_next = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_next = ST_DEAD;
               w_presc_next = '0;
               w_index_next = '0;
               w_load       = 1'b1;
            end
            ST_DEAD: begin
               w_presc_next = r_presc + CW'(1);
               if (r_presc == DEAD_LAST)
                  w_state_next = ST_DRIVE;
            end
            ST_DRIVE: begin
               if (w_slot_end) begin
                  w_state_next = ST_DEAD;
                  w_presc_next = '0;
                  w_index_next = r_index + 2'd1;
                  w_load       = (r_index == 2'd3);
               end else begin
                  w_presc_next = r_presc + CW'(1);
               end
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_presc <= '0;
         r_index <= '0;
         r_value <= '0;
         r_dp    <= '0;
         r_blz   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_presc <= w_presc_next;
         r_index <= w_index_next;
         if (w_load) begin
            r_value <= value_in;
            r_dp    <= dp_in;
            r_blz   <= blank_lz;
         end
      end
   end

   assign w_nibble = r_value[{r_index, 2'b00} +: 4];
   // Blank when this digit and every more-significant digit are zero.
   assign w_blank  = r_blz && (r_index != 2'd0) &&
                     ((r_value >> {r_index, 2'b00}) == 16'h0000);

   hex_seg_decoder u_dec (
      .i_nibble (w_nibble),
      .o_seg_n  (w_seg_dec)
   );

   // Outputs follow the state register by one cycle; a low enable darkens
   // them on the same edge the state returns to idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_seg        <= SEG_BLANK;
         r_dp_n       <= 1'b1;
         r_an         <= AN_OFF;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_load;
         if (enable && (r_state == ST_DRIVE)) begin
            r_an   <= ~(4'b0001 << r_index);
            r_seg  <= w_blank ? SEG_BLANK : w_seg_dec;
            r_dp_n <= ~r_dp[r_index];
         end else begin
            r_an   <= AN_OFF;
            r_seg  <= SEG_BLANK;
            r_dp_n <= 1'b1;
         end
      end
   end

   assign seg_n      = r_seg;
   assign dp_n       = r_dp_n;
   assign an_n       = r_an;
   assign frame_tick = r_frame_tick;

endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001: Parameter TICK_DIV, default 50000, clk cycles per digit slot (1 kHz digit rate at 50 MHz); legal range TICK_DIV > DEAD_CYCLES+1.
REQ-002: Parameter DEAD_CYCLES, default 16, cycles of all-anodes-off at the start of each slot (anti-ghosting); legal range DEAD_CYCLES >= 1.
REQ-003: clk  input  1  system clock; all logic on rising edge.
REQ-004: reset_n  input  1  reset, asynchronous, active-low.
REQ-005: value_in  input  16  four hex nibbles from the hex-digits PIO out_port; nibble k [4k+3:4k] shows on digit k.
REQ-006: dp_in  input  4  decimal-point request per digit, 1 = lit.
REQ-007: blank_lz  input  1  1 = blank leading zeros.
REQ-008: enable  input  1  1 = scan, 0 = display dark.
REQ-009: seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010: dp_n  output  1  decimal point, active-low.
REQ-011: an_n  output  4  digit anodes, active-low, one-hot-low or all high.
REQ-012: frame_tick  output  1  one-cycle pulse when a new frame snapshot is latched.

Function
REQ-013: Prescaler counts 0..TICK_DIV-1, wraps to 0; slot_end asserts in the cycle the count equals TICK_DIV-1.
REQ-014: Digit index counts 0..3, advances on slot_end, wraps 3->0.
REQ-015: value_in and dp_in SHALL be sampled into shadow registers only at the start of slot 0 (the cycle after slot_end with index 3, or the first cycle after enable rises); frame_tick pulses in that same cycle; mid-frame input changes never appear until the next frame.
REQ-016: State machine: IDLE, DEAD, DRIVE. IDLE -> DEAD when enable=1; DEAD -> DRIVE after DEAD_CYCLES cycles; DRIVE -> DEAD on slot_end; any state -> IDLE when enable=0.
REQ-017: In IDLE and DEAD: an_n=4'hF, seg_n=7'h7F, dp_n=1.
REQ-018: In DRIVE: an_n bit [index]=0, others 1; seg_n = decode(shadow nibble[index]); dp_n = ~shadow_dp[index].
REQ-019: Decode (active-low, gfedcba): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-020: Leading-zero blanking: with shadow blank_lz=1, digit k (k=3,2,1) is blanked (seg_n=7'h7F, anode still driven) when nibbles k..3 are all zero; digit 0 never blanked; dp_n unaffected by blanking. blank_lz is shadowed with value_in.
REQ-021: All outputs registered; pins reflect state/index with exactly one cycle latency.
REQ-022: enable falling mid-slot: next cycle outputs dark, prescaler and index cleared to 0; shadow registers held.
REQ-023: enable rising: new snapshot latched, index 0, DEAD entered, prescaler from 0.

Reset
REQ-024: During reset_n=0: seg_n=7'h7F, dp_n=1, an_n=4'hF, frame_tick=0, state IDLE, prescaler/index/shadows 0.
REQ-025: Reset assertion asynchronous; deassertion takes effect on the first clk edge after reset_n rises; reset mid-frame aborts the frame with no partial glitch beyond the async output clear.

Structure
REQ-026: Shared package hex_display_pkg holds the state enum, SEG_BLANK=7'h7F, AN_OFF=4'hF and the 16-entry segment table.
REQ-027: One combinational sub-module hex_seg_decoder (4-bit nibble -> 7-bit active-low segments) instantiated once on the indexed shadow nibble.

Verification (TICK_DIV=8, DEAD_CYCLES=2)
REQ-028: Reset release, enable=1, value_in=16'h1234 -> frame_tick once; per slot 2 dark cycles then 6 cycles an_n=4'hE seg_n=7'h19, then 4'hD/7'h30, 4'hB/7'h24, 4'h7/7'h79.
REQ-029: value_in changes 16'h1234->16'hABCD during slot 1 -> remaining slots still show 1234; next frame shows D,C,b,A (7'h21,7'h46,7'h03,7'h08).
REQ-030: blank_lz=1, value_in=16'h0050 -> digits 3,2 seg_n=7'h7F, digit 1 7'h12, digit 0 7'h40; value_in=16'h0000 -> only digit 0 lit with 7'h40.
REQ-031: dp_in=4'b0101, value_in=16'h8888 -> dp_n=0 on digits 0,2, 1 on digits 1,3, seg_n=7'h00 throughout DRIVE.
REQ-032: enable dropped mid-slot 2 -> next cycle all outputs dark; re-enable -> frame_tick, digit 0 after 2 dark cycles.
REQ-033: reset_n pulsed low mid-DRIVE (asynchronous to clk) -> outputs dark immediately, IDLE after release until enable sampled high.
